fp_divider32: RTL and testbench
===============================

FP_DIVIDER32 -- requirements
Module: fp_divider32

Interface
REQ-001 The block SHALL have no parameters; operand format is fixed to IEEE-754 single precision.
REQ-002 The block SHALL provide these ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  32  dividend, IEEE-754 single.
- b  input  32  divisor, IEEE-754 single.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- q  output  32  quotient a/b.
- div_by_zero  output  1  finite non-zero a divided by zero.
- invalid  output  1  NaN operand, 0/0 or inf/inf.
- overflow  output  1  result exponent saturated to infinity.
- underflow  output  1  result flushed to zero.

Function
REQ-003 The block SHALL implement states IDLE, DIVIDE, NORM and DONE.
REQ-004 In IDLE with start=1, it SHALL capture a and b at that edge (edge N) and leave IDLE; start in any other state SHALL be ignored.
REQ-005 It SHALL treat an operand with exponent field 0 as signed zero (denormals flushed on input).
REQ-006 Special cases SHALL be resolved from the captured operands and go straight to DONE:
- any NaN, 0/0 or inf/inf: q=32'h7FC00000, invalid=1.
- finite non-zero/0: q=signed inf, div_by_zero=1.
- inf/finite: q=signed inf.
- 0/non-zero or finite/inf: q=signed zero.
REQ-007 Result sign SHALL always be a[31]^b[31], except for the NaN result.
REQ-008 Otherwise it SHALL enter DIVIDE with 24-bit mantissas (hidden bit set) and a 10-bit signed exponent ea-eb.
REQ-009 DIVIDE SHALL run restoring division, one quotient bit per cycle, for exactly 25 cycles, producing quot[24:0] MSB first; quot[24] has weight 2^0.
REQ-010 Each DIVIDE step SHALL compute remainder-minus-divisor with a subtractor (adder with inverted divisor, carry-in 1), and keep the difference when there is no borrow.
REQ-011 NORM SHALL use quot[24] to select the result:
- quot[24]=1: frac=quot[23:1], exp=ea-eb+127.
- quot[24]=0: frac=quot[22:0], exp=ea-eb+126.
REQ-012 Rounding SHALL be truncation (round toward zero); remaining remainder bits SHALL be discarded.
REQ-013 In NORM, exp>=255 SHALL give signed inf with overflow=1, and exp<=0 SHALL give signed zero with underflow=1.
REQ-014 q and all flags SHALL be registered in DONE. done SHALL be high for exactly the cycle in DONE, after which the block returns to IDLE.
REQ-015 Latency SHALL be fixed:
- special cases: done high in the cycle after edge N+1.
- normal operands: done high in the cycle after edge N+27.
REQ-016 q and the flags SHALL hold until the next accepted start. At that edge all four flags SHALL clear.
REQ-017 busy SHALL be 1 from the edge after N through the DONE cycle inclusive.
REQ-018 Changes on a and b after edge N SHALL NOT affect the result.

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE and drive busy, done, q, div_by_zero, invalid, overflow and underflow to 0, and clear the internal remainder, quotient and exponent.
REQ-020 Reset asserted mid-DIVIDE SHALL abandon the operation with no done pulse. The first start after rst_n rises SHALL be accepted normally.

Verification
REQ-021 a=40C00000, b=40000000 (6/2) -> q=40400000, all flags 0, done at N+27.
REQ-022 a=3F800000, b=40400000 (1/3) -> q=3EAAAAAA (truncated), flags 0.
REQ-023 a=BF800000, b=00000000 -> q=FF800000, div_by_zero=1, done at N+1; a=0, b=0 -> q=7FC00000, invalid=1.
REQ-024 a=7F000000, b=3F000000 -> q=7F800000, overflow=1; a=00800000, b=40000000 -> q=00000000, underflow=1.
REQ-025 Pulse start again at N+5 with different operands -> ignored; first result is delivered unchanged at N+27.
REQ-026 Pulse rst_n low at N+10 -> busy=0 and q=0 immediately, no done pulse; a new 6/2 request afterwards returns 40400000.

Source files
------------

// File: rtl/fp_divider32.sv
// fp_divider32: IEEE-754 single-precision divider built on a bit-serial restoring divider.
// Denormal operands flush to signed zero; the quotient is truncated toward zero.
module fp_divider32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic        div_by_zero,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             r_state;
  state_t             w_next;
  logic        [31:0] r_a;
  logic        [31:0] r_b;
  logic        [4:0]  r_cnt;
  logic        [24:0] r_rem;
  logic        [23:0] r_div;
  logic        [24:0] r_quot;
  logic signed [9:0]  r_exp;
  logic               r_busy;
  logic               r_done;
  logic        [31:0] r_q;
  logic               r_div_by_zero;
  logic               r_invalid;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_sign;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_nan;
  logic               w_b_nan;
  logic               w_special;
  logic        [31:0] w_sp_q;
  logic               w_sp_dbz;
  logic               w_sp_inv;
  logic        [25:0] w_sub;
  logic               w_no_borrow;
  logic        [24:0] w_rem_keep;
  logic signed [9:0]  w_exp_n;
  logic        [22:0] w_frac;
  logic        [31:0] w_norm_q;
  logic               w_norm_ovf;
  logic               w_norm_unf;

  assign busy        = r_busy;
  assign done        = r_done;
  assign q           = r_q;
  assign div_by_zero = r_div_by_zero;
  assign invalid     = r_invalid;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_a_zero = (r_a[30:23] == 8'd0);
  assign w_b_zero = (r_b[30:23] == 8'd0);
  assign w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_special = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;

  // Special-operand result selection (only consumed when w_special is set)
  always_comb begin
    w_sp_q   = 32'd0;
    w_sp_dbz = 1'b0;
    w_sp_inv = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_sp_q   = QNAN;
      w_sp_inv = 1'b1;
    end else if (w_b_zero) begin
      w_sp_q   = {w_sign, 8'hFF, 23'd0};
      w_sp_dbz = ~w_a_inf;
    end else if (w_a_inf) begin
      w_sp_q   = {w_sign, 8'hFF, 23'd0};
    end else begin
      w_sp_q   = {w_sign, 31'd0};
    end
  end

  // Trial subtraction: carry out of rem + ~div + 1 means no borrow
  assign w_sub       = {1'b0, r_rem} + {1'b0, ~{1'b0, r_div}} + 26'd1;
  assign w_no_borrow = w_sub[25];
  assign w_rem_keep  = w_no_borrow ? w_sub[24:0] : r_rem;

  // Normalisation, exponent range check and result packing
  always_comb begin
    w_exp_n    = r_exp + (r_quot[24] ? 10'sd127 : 10'sd126);
    w_frac     = r_quot[24] ? r_quot[23:1] : r_quot[22:0];
    w_norm_ovf = 1'b0;
    w_norm_unf = 1'b0;
    if (w_exp_n >= 10'sd255) begin
      w_norm_q   = {w_sign, 8'hFF, 23'd0};
      w_norm_ovf = 1'b1;
    end else if (w_exp_n <= 10'sd0) begin
      w_norm_q   = {w_sign, 31'd0};
      w_norm_unf = 1'b1;
    end else begin
      w_norm_q   = {w_sign, w_exp_n[7:0], w_frac};
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = DIVIDE;
        else       w_next = IDLE;
      end
      DIVIDE: begin
        if ((r_cnt == 5'd0) && w_special) w_next = DONE;
        else if (r_cnt == 5'd25)          w_next = NORM;
        else                              w_next = DIVIDE;
      end
      NORM:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == DONE);
    end
  end

  // Datapath: capture, classify/setup (count 0), 25 division steps, normalise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a           <= 32'd0;
      r_b           <= 32'd0;
      r_cnt         <= 5'd0;
      r_rem         <= 25'd0;
      r_div         <= 24'd0;
      r_quot        <= 25'd0;
      r_exp         <= 10'sd0;
      r_q           <= 32'd0;
      r_div_by_zero <= 1'b0;
      r_invalid     <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a           <= a;
            r_b           <= b;
            r_cnt         <= 5'd0;
            r_div_by_zero <= 1'b0;
            r_invalid     <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
          end
        end
        DIVIDE: begin
          if (r_cnt == 5'd0) begin
            if (w_special) begin
              r_q           <= w_sp_q;
              r_div_by_zero <= w_sp_dbz;
              r_invalid     <= w_sp_inv;
            end
            r_rem  <= {2'b01, r_a[22:0]};
            r_div  <= {1'b1, r_b[22:0]};
            r_exp  <= $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]});
            r_quot <= 25'd0;
          end else begin
            r_rem  <= w_rem_keep << 1;
            r_quot <= {r_quot[23:0], w_no_borrow};
          end
          r_cnt <= r_cnt + 5'd1;
        end
        NORM: begin
          r_q         <= w_norm_q;
          r_overflow  <= w_norm_ovf;
          r_underflow <= w_norm_unf;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider32.sv
// Randomised self-checking bench for fp_divider32 against an arithmetic reference model.
module tb_fp_divider32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic        div_by_zero;
  logic        invalid;
  logic        overflow;
  logic        underflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_cnt = 0;
  int          n_edge   = 0;
  int          lat      = 0;
  bit          track    = 1'b0;
  logic [31:0] exp_q    = 32'd0;
  logic [31:0] prev_q   = 32'd0;
  logic [3:0]  exp_flags = 4'd0;

  fp_divider32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .div_by_zero(div_by_zero),
    .invalid(invalid), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: flags packed as {div_by_zero, invalid, overflow, underflow}
  task automatic model(input logic [31:0] ta, input logic [31:0] tb_op,
                       output logic [31:0] mq, output logic [3:0] mf, output int ml);
    int unsigned ea, eb;
    bit za, zb, ia, ib, na, nb, s;
    longint unsigned ma, mb, qt;
    int e;
    int unsigned frac;
    ea = ta[30:23];  eb = tb_op[30:23];
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == 255) && (ta[22:0] == 0);    ib = (eb == 255) && (tb_op[22:0] == 0);
    na = (ea == 255) && (ta[22:0] != 0);    nb = (eb == 255) && (tb_op[22:0] != 0);
    s  = ta[31] ^ tb_op[31];
    mf = 4'b0000;
    ml = 1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      mq = 32'h7FC0_0000;  mf = 4'b0100;
    end else if (zb) begin
      mq = {s, 8'hFF, 23'd0};  mf = ia ? 4'b0000 : 4'b1000;
    end else if (ia) begin
      mq = {s, 8'hFF, 23'd0};
    end else if (za || ib) begin
      mq = {s, 31'd0};
    end else begin
      ml = 27;
      ma = 64'h80_0000 + ta[22:0];
      mb = 64'h80_0000 + tb_op[22:0];
      qt = (ma << 24) / mb;
      e  = int'(ea) - int'(eb) + 127;
      if (qt >= 64'h100_0000) begin
        frac = int'((qt >> 1) & 64'h7F_FFFF);
      end else begin
        e    = e - 1;
        frac = int'(qt & 64'h7F_FFFF);
      end
      if (e >= 255) begin
        mq = {s, 8'hFF, 23'd0};  mf = 4'b0010;
      end else if (e <= 0) begin
        mq = {s, 31'd0};  mf = 4'b0001;
      end else begin
        mq = {s, 8'(e), 23'(frac)};
      end
    end
  endtask

  // Cycle-by-cycle compare relative to the accepting edge N
  always @(negedge clk) begin
    int k;
    if (track) begin
      k = edge_cnt - n_edge;
      check("busy", {31'd0, busy}, {31'd0, (k <= lat)});
      check("done", {31'd0, done}, {31'd0, (k == lat)});
      if (k < lat) begin
        check("q_hold", q, prev_q);
        check("flags_clear", {28'd0, div_by_zero, invalid, overflow, underflow}, 32'd0);
      end else begin
        check("q", q, exp_q);
        check("flags", {28'd0, div_by_zero, invalid, overflow, underflow}, {28'd0, exp_flags});
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_op, input bit glitch);
    logic [31:0] mq;
    logic [3:0]  mf;
    int          ml;
    model(ta, tb_op, mq, mf, ml);
    a = ta;  b = tb_op;  start = 1'b1;
    @(posedge clk);
    #1;
    n_edge = edge_cnt;  prev_q = exp_q;  exp_q = mq;  exp_flags = mf;  lat = ml;
    track = 1'b1;
    start = 1'b0;  a = $urandom;  b = $urandom;
    if (glitch && ml > 6) begin
      repeat (5) @(negedge clk);
      start = 1'b1;  a = 32'h4120_0000;  b = 32'h3F80_0000;
      @(negedge clk);
      start = 1'b0;
      repeat (ml - 4) @(negedge clk);
    end else begin
      repeat (ml + 2) @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    int unsigned cat;
    logic [31:0] v;
    cat = $urandom_range(0, 11);
    v   = $urandom;
    case (cat)
      0:       v[30:23] = 8'd0;
      1:       begin v[30:23] = 8'hFF;  v[22:0] = 23'd0; end
      2:       begin v[30:23] = 8'hFF;  v[0] = 1'b1; end
      3:       v[30:23] = 8'($urandom_range(1, 6));
      4:       v[30:23] = 8'($urandom_range(249, 254));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  logic [31:0] pin_a [8] = '{32'h40C0_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000,
                             32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 32'h3F80_0000};
  logic [31:0] pin_b [8] = '{32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000,
                             32'h3F00_0000, 32'h4000_0000, 32'hC000_0000, 32'hFF80_0000};
  logic [31:0] pin_q [8] = '{32'h4040_0000, 32'h3EAA_AAAA, 32'hFF80_0000, 32'h7FC0_0000,
                             32'h7F80_0000, 32'h0000_0000, 32'hFF80_0000, 32'h8000_0000};
  logic [3:0]  pin_f [8] = '{4'b0000, 4'b0000, 4'b1000, 4'b0100,
                             4'b0010, 4'b0001, 4'b0000, 4'b0000};
  int          pin_l [8] = '{27, 27, 1, 1, 27, 27, 1, 1};

  initial begin
    logic [31:0] mq;
    logic [3:0]  mf;
    int          ml;
    rst_n = 1'b0;  start = 1'b0;  a = 32'd0;  b = 32'd0;

    for (int i = 0; i < 8; i++) begin
      model(pin_a[i], pin_b[i], mq, mf, ml);
      check("model_q", mq, pin_q[i]);
      check("model_flags", {28'd0, mf}, {28'd0, pin_f[i]});
      check("model_lat", ml, pin_l[i]);
    end

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_flags", {28'd0, div_by_zero, invalid, overflow, underflow}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(pin_a[i], pin_b[i], 1'b0);
    run_txn(32'h40C0_0000, 32'h4000_0000, 1'b1);

    // Abandon an operation with reset at edge N+10
    run_txn_abort();

    for (int i = 0; i < 150; i++) run_txn(rand_operand(), rand_operand(), (i % 17) == 3);

    track = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic run_txn_abort();
    a = 32'h40C0_0000;  b = 32'h4000_0000;  start = 1'b1;
    @(posedge clk);
    #1;
    n_edge = edge_cnt;  prev_q = exp_q;  exp_q = 32'h4040_0000;  exp_flags = 4'd0;  lat = 27;
    track = 1'b1;  start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    track = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_q", q, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_flags", {28'd0, div_by_zero, invalid, overflow, underflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q = 32'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
      check("abort_idle", {31'd0, busy}, 32'd0);
    end
    run_txn(32'h40C0_0000, 32'h4000_0000, 1'b0);
  endtask

endmodule
